// File: rtl/switch_output_arbiter_pkg.sv
// Shared switch definitions: port count, port indices, arbiter state
// encoding and flit control bit positions (also used by the input buffers).
package switch_output_arbiter_pkg;

    localparam int NUM_PORTS = 5;
    localparam int PTR_W     = 3;

    localparam int PORT_N = 0;
    localparam int PORT_E = 1;
    localparam int PORT_S = 2;
    localparam int PORT_W = 3;
    localparam int PORT_L = 4;

    // Flit layout: payload in the low bits, control bits on top.
    localparam int FLIT_W        = 34;
    localparam int FLIT_TAIL_BIT = 32;
    localparam int FLIT_HEAD_BIT = 33;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/switch_output_arbiter_if.sv
// Arbiter handshake bundle for one output port.
//   req/in_valid/in_tail : per-input request, flit valid, flit tail
//   out_ready            : downstream can take a flit
//   grant/in_ready       : one-hot mux select and per-input pop strobe
//   out_valid/busy       : granted flit valid, arbiter locked
// slave = arbiter side, master = input buffers / link side.
interface switch_output_arbiter_if
    import switch_output_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = switch_output_arbiter_pkg::NUM_PORTS
);
    logic [NUM_PORTS-1:0] req;
    logic [NUM_PORTS-1:0] in_valid;
    logic [NUM_PORTS-1:0] in_tail;
    logic                 out_ready;
    logic [NUM_PORTS-1:0] grant;
    logic [NUM_PORTS-1:0] in_ready;
    logic                 out_valid;
    logic                 busy;

    modport slave (
        input  req, in_valid, in_tail, out_ready,
        output grant, in_ready, out_valid, busy
    );

    modport master (
        output req, in_valid, in_tail, out_ready,
        input  grant, in_ready, out_valid, busy
    );
endinterface

// File: rtl/switch_output_arbiter_rr_priority_pick.sv
// Combinational round-robin finder: scans req starting at ptr, wrapping
// NUM_PORTS-1 -> 0, and returns the first requester as one-hot + index.
//   req     : request vector
//   ptr     : highest-priority index (always < NUM_PORTS)
//   win     : one-hot winner, zero when req == 0
//   win_idx : binary index of the winner (0 when none)
module rr_priority_pick
    import switch_output_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = switch_output_arbiter_pkg::NUM_PORTS,
    parameter int PTR_W     = switch_output_arbiter_pkg::PTR_W
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PTR_W-1:0]     ptr,
    output logic [NUM_PORTS-1:0] win,
    output logic [PTR_W-1:0]     win_idx
);

    always_comb begin
        int  s;
        logic found;
        s       = 0;
        found   = 1'b0;
        win     = '0;
        win_idx = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            // ptr < NUM_PORTS, so a single conditional subtract is the modulo.
            s = int'(ptr) + k;
            if (s >= NUM_PORTS) s = s - NUM_PORTS;
            if (!found && req[s]) begin
                found      = 1'b1;
                win[s]     = 1'b1;
                win_idx    = PTR_W'(s);
            end
        end
    end

endmodule

// File: rtl/switch_output_arbiter.sv
// Per-output round-robin arbiter for the 5-port mesh switch. Picks one
// requesting input, holds a registered one-hot grant from head to tail
// flit, then releases with the winner dropped to lowest priority.
//   clk, rst : clock, async active-high reset
//   bus      : handshake bundle (slave side)
module switch_output_arbiter
    import switch_output_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = switch_output_arbiter_pkg::NUM_PORTS,
    parameter int PTR_W     = switch_output_arbiter_pkg::PTR_W
) (
    input  logic                    clk,
    input  logic                    rst,
    switch_output_arbiter_if.slave  bus
);

    arb_state_t           state, state_n;
    logic [PTR_W-1:0]     ptr, ptr_n;
    logic [PTR_W-1:0]     g_idx, g_idx_n;
    logic [NUM_PORTS-1:0] grant, grant_n;
    logic [NUM_PORTS-1:0] win;
    logic [PTR_W-1:0]     win_idx;
    logic                 xfer, tail_xfer;

    rr_priority_pick #(.NUM_PORTS(NUM_PORTS), .PTR_W(PTR_W)) u_pick (
        .req     (bus.req),
        .ptr     (ptr),
        .win     (win),
        .win_idx (win_idx)
    );

    assign bus.grant     = grant;
    assign bus.in_ready  = grant & {NUM_PORTS{bus.out_ready}};
    assign bus.out_valid = |(grant & bus.in_valid);
    assign bus.busy      = (state == LOCKED);

    assign xfer      = bus.out_valid & bus.out_ready;
    // grant is one-hot while locked, so this selects in_tail[g].
    assign tail_xfer = xfer & |(grant & bus.in_tail);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            g_idx <= '0;
            grant <= '0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            g_idx <= g_idx_n;
            grant <= grant_n;
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        g_idx_n = g_idx;
        grant_n = grant;
        case (state)
            IDLE: begin
                if (|bus.req) begin
                    state_n = LOCKED;
                    grant_n = win;
                    g_idx_n = win_idx;
                end
            end
            LOCKED: begin
                if (tail_xfer) begin
                    state_n = IDLE;
                    grant_n = '0;
                    ptr_n   = (g_idx == PTR_W'(NUM_PORTS - 1)) ? '0 : g_idx + PTR_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                grant_n = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_switch_output_arbiter.sv
// Directed + randomized-invariant bench for switch_output_arbiter.
module tb_switch_output_arbiter;
    import switch_output_arbiter_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    switch_output_arbiter_if #(.NUM_PORTS(NUM_PORTS)) bus ();

    switch_output_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int ors [5];
        int nx;
        logic [4:0] bv [4];
        logic [4:0] bt [4];
        logic [4:0] exp_seq [4];
        int waits [NUM_PORTS];
        logic arb;
        logic [NUM_PORTS-1:0] snap;

        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        bus.req = '0; bus.in_valid = '0; bus.in_tail = '0; bus.out_ready = 1'b0;

        // Reset state
        #3;
        check("rst_grant", 32'(bus.grant), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_in_ready", 32'(bus.in_ready), 32'h0);
        check("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("rst_ptr", 32'(dut.ptr), 32'h0);
        #3;
        rst = 1'b0;

        // Single request, single-flit packet
        bus.req = 5'b00100;
        #1;
        check("t1_no_same_cycle_grant", 32'(bus.grant), 32'h0);
        tick();
        check("t1_grant", 32'(bus.grant), 32'b00100);
        check("t1_busy", 32'(bus.busy), 32'h1);
        bus.req = '0; bus.in_valid = 5'b00100; bus.in_tail = 5'b00100; bus.out_ready = 1'b1;
        #1;
        check("t1_in_ready", 32'(bus.in_ready), 32'b00100);
        check("t1_out_valid", 32'(bus.out_valid), 32'h1);
        tick();
        check("t1_release", 32'(bus.grant), 32'h0);
        check("t1_busy_off", 32'(bus.busy), 32'h0);
        check("t1_ptr", 32'(dut.ptr), 32'h3);

        // Round-robin over req=10011 from ptr=0, single-flit packets
        pulse_reset();
        exp_seq = '{5'b00001, 5'b00010, 5'b10000, 5'b00001};
        bus.req = 5'b10011; bus.in_valid = 5'b11111; bus.in_tail = 5'b11111; bus.out_ready = 1'b1;
        for (int p = 0; p < 4; p++) begin
            tick();
            check($sformatf("t2_grant%0d", p), 32'(bus.grant), 32'(exp_seq[p]));
            if (p == 3) bus.req = '0;
            tick();
            check($sformatf("t2_gap%0d", p), 32'(bus.grant), 32'h0);
        end
        // ptr now 1

        // Lock hold across a 4-flit packet with stalls
        bus.req = 5'b00011; bus.in_valid = 5'b00011; bus.in_tail = '0; bus.out_ready = 1'b0;
        tick();
        check("t3_grant", 32'(bus.grant), 32'b00010);
        ors = '{1, 0, 1, 1, 1};
        nx = 0;
        for (int c = 0; c < 5; c++) begin
            bus.out_ready = ors[c][0];
            bus.in_tail = (ors[c] == 1 && nx == 3) ? 5'b00010 : 5'b00000;
            #1;
            check($sformatf("t3_hold%0d", c), 32'(bus.grant), 32'b00010);
            check($sformatf("t3_in_ready%0d", c), 32'(bus.in_ready), (ors[c] == 1) ? 32'b00010 : 32'h0);
            if (ors[c] == 1) nx++;
            tick();
        end
        check("t3_release", 32'(bus.grant), 32'h0);
        check("t3_ptr", 32'(dut.ptr), 32'h2);
        bus.in_tail = '0; bus.out_ready = 1'b0;
        tick();
        check("t3_next_input0", 32'(bus.grant), 32'b00001);
        bus.req = '0; bus.in_valid = 5'b00001; bus.in_tail = 5'b00001; bus.out_ready = 1'b1;
        tick();
        check("t3_release2", 32'(bus.grant), 32'h0);

        // Bubble mid-packet on input 3 (ptr=1)
        bus.req = 5'b01000; bus.in_valid = '0; bus.in_tail = '0; bus.out_ready = 1'b0;
        tick();
        check("t4_grant", 32'(bus.grant), 32'b01000);
        bus.req = '0; bus.out_ready = 1'b1;
        bv = '{5'b01000, 5'b00000, 5'b00000, 5'b01000};
        bt = '{5'b00000, 5'b00000, 5'b00000, 5'b01000};
        for (int c = 0; c < 4; c++) begin
            bus.in_valid = bv[c]; bus.in_tail = bt[c];
            #1;
            check($sformatf("t4_out_valid%0d", c), 32'(bus.out_valid), 32'(bv[c][3]));
            check($sformatf("t4_hold%0d", c), 32'(bus.grant), 32'b01000);
            tick();
        end
        check("t4_release", 32'(bus.grant), 32'h0);
        check("t4_ptr", 32'(dut.ptr), 32'h4);

        // Asynchronous reset mid-packet
        bus.req = 5'b10000; bus.in_valid = 5'b10000; bus.in_tail = '0; bus.out_ready = 1'b1;
        tick();
        check("t5_grant", 32'(bus.grant), 32'b10000);
        check("t5_in_ready", 32'(bus.in_ready), 32'b10000);
        #2;
        rst = 1'b1;
        #1;
        check("t5_async_grant", 32'(bus.grant), 32'h0);
        check("t5_async_in_ready", 32'(bus.in_ready), 32'h0);
        check("t5_async_busy", 32'(bus.busy), 32'h0);
        #1;
        rst = 1'b0;
        check("t5_ptr", 32'(dut.ptr), 32'h0);
        bus.req = 5'b10001; bus.in_valid = '0;
        tick();
        check("t5_regrant", 32'(bus.grant), 32'b00001);

        // Random invariants and starvation bound
        pulse_reset();
        for (int i = 0; i < NUM_PORTS; i++) waits[i] = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            bus.req       = 5'($urandom);
            bus.in_valid  = 5'($urandom);
            bus.in_tail   = 5'($urandom) & 5'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            check("r_onehot", 32'($onehot0(bus.grant)), 32'h1);
            check("r_ready_no_grant", 32'(bus.in_ready & ~bus.grant), 32'h0);
            arb  = !bus.busy && (bus.req != '0);
            snap = bus.req;
            tick();
            if (arb) begin
                check("r_arb_grant", 32'(bus.grant != '0), 32'h1);
                for (int i = 0; i < NUM_PORTS; i++) begin
                    if (snap[i] && !bus.grant[i]) waits[i]++;
                    else waits[i] = 0;
                    check($sformatf("r_starve%0d", i), 32'(waits[i] <= 4), 32'h1);
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/switch_output_arbiter.md
Name: switch_output_arbiter

Overview:
- Per-output-port arbiter for the 5-port mesh switch. One instance sits in front of each output's 5:1 crossbar mux.
- Takes packet requests from the N, E, S, W and Local input buffers and picks one with round-robin fairness.
- Produces a registered one-hot grant that drives the mux select directly. The grant is held for the whole packet, head through tail, using a valid/ready flit handshake.

Parameters:
- NUM_PORTS, 5, number of requesting inputs. Also the grant width; the mux select is 5 bits one-hot.
- PTR_W, 3, width of the round-robin pointer. Must satisfy 2**PTR_W >= NUM_PORTS.

Ports:
- clk  input  1  single clock
- rst  input  1  reset, asynchronous, active-high
- req  input  NUM_PORTS  req[i]=1: input i holds a head flit routed to this output
- in_valid  input  NUM_PORTS  in_valid[i]=1: input i presents a valid flit
- in_tail  input  NUM_PORTS  in_tail[i]=1: input i's current flit is a tail (head+tail allowed)
- out_ready  input  1  downstream link/buffer can accept a flit this cycle
- grant  output  NUM_PORTS  registered one-hot mux select; all-zero when idle
- in_ready  output  NUM_PORTS  per-input pop strobe, equal to grant & {NUM_PORTS{out_ready}}
- out_valid  output  1  |(grant & in_valid)
- busy  output  1  1 while in state LOCKED

Behaviour:
- Clock/reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset state: grant=0, ptr=0, state=IDLE, busy=0. in_ready=0 and out_valid=0 follow combinationally.
- Reset mid-packet: the grant drops immediately and asynchronously. The partially sent packet is abandoned; no recovery is attempted.
- States: IDLE and LOCKED.
- IDLE behaviour:
  - If req != 0, search starting at index ptr, wrapping NUM_PORTS-1 -> 0. The first i with req[i]=1 wins.
  - Next edge: grant <= onehot(i), state <= LOCKED.
  - If req == 0, stay in IDLE.
- Latency: req asserted at edge t gives grant visible after edge t+1. No grant in the same cycle as the request.
- LOCKED behaviour:
  - grant is held constant and req is ignored, both for the granted input and for all others.
  - A transfer occurs in a cycle where out_valid & out_ready = 1.
  - Transfer with in_tail[g]=1, where g is the granted index, releases the lock at the next edge: grant <= 0, ptr <= (g+1) mod NUM_PORTS, state <= IDLE.
  - Transfer without the tail flag: stay LOCKED.
  - in_valid[g]=0 (bubble): out_valid=0, no transfer, stay LOCKED.
- Single-flit packet (head and tail in one flit): locks for exactly one transfer, then releases.
- Back-to-back packets:
  - After a release, one IDLE cycle always follows, so the minimum gap between packets is 1 cycle.
  - The released input gets lowest priority in the next arbitration.
- Pointer wrap: ptr=4 and release of index 4 give ptr=0. ptr never takes values >= NUM_PORTS.
- Invariants:
  - grant is always 0 or exactly one-hot.
  - in_ready is never asserted for a non-granted input.
- out_ready low: in_ready is all-zero; grant and state are unchanged.
- Simultaneous requests: resolved strictly by the rotated priority starting at ptr, not by index.

Decomposition:
- Shared switch package holds:
  - NUM_PORTS=5
  - port index constants PORT_N=0, PORT_E=1, PORT_S=2, PORT_W=3, PORT_L=4
  - state encoding IDLE/LOCKED
  - the flit head/tail bit positions, also used by the input buffers
- One natural sub-module: rr_priority_pick. This is a combinational rotate-and-first-one finder taking req and ptr, returning a one-hot winner and its index. The arbiter keeps only state, ptr and the grant register.

Test Plan:
- Reset, then req=5'b00100 at cycle 1 -> grant=5'b00100 at cycle 2, busy=1. With in_valid[2]=1, in_tail[2]=1 and out_ready=1 -> grant=0 at cycle 3, ptr=3.
- From ptr=0, req=5'b10011 held over three packets, each single-flit -> grants in order 00001, 00010, 10000, then 00001 again (wrap).
- Lock hold: grant=00010 on a 4-flit packet with out_ready toggling 1,0,1,1,1 and req[0] asserted throughout -> grant stays 00010 for all 4 transfers, in_ready[1] mirrors out_ready, input 0 is granted only after the tail.
- Bubble: grant=01000 with in_valid[3]=0 for 2 cycles mid-packet -> out_valid=0, no release, lock kept until the tail transfer.
- Async reset mid-packet: grant=10000, rst asserted between clock edges -> grant=0 and in_ready=0 immediately. After rst drops, req=5'b10001 gives grant=00001 (ptr back at 0).
- Invariant check under random req/in_valid/in_tail/out_ready for 10k cycles -> grant is never multi-hot, no in_ready without grant, and every requesting input is granted within 4 packets.
